// File: rtl/multi_mode_flip_flop_bank.sv
// WIDTH-bit register bank whose bits behave as D, T, JK or SR flip-flops under a
// shared run-time mode, plus left/right shift and an up-counter mode.
module multi_mode_flip_flop_bank #(
  parameter int                WIDTH       = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             wrap,
  output logic             sr_conflict
);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_D     = 3'b001;
  localparam logic [2:0] MODE_T     = 3'b010;
  localparam logic [2:0] MODE_JK    = 3'b011;
  localparam logic [2:0] MODE_SR    = 3'b100;
  localparam logic [2:0] MODE_SHL   = 3'b101;
  localparam logic [2:0] MODE_SHR   = 3'b110;
  localparam logic [2:0] MODE_COUNT = 3'b111;

  logic [WIDTH-1:0] q_next;
  logic             ser_next;
  logic             wrap_next;
  logic             conflict_next;
  logic [WIDTH-1:0] sr_set;
  logic [WIDTH-1:0] sr_clr;

  // In SR mode a bit with S=R=1 is in neither mask, so it holds.
  assign sr_set = a & ~b;
  assign sr_clr = ~a & b;

  always_comb begin
    q_next        = q;
    ser_next      = ser_out;
    wrap_next     = 1'b0;
    conflict_next = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD:  q_next = q;
        MODE_D:     q_next = a;
        MODE_T:     q_next = q ^ a;
        MODE_JK:    q_next = (a & ~q) | (~b & q);
        MODE_SR: begin
          q_next        = (q & ~sr_clr) | sr_set;
          conflict_next = |(a & b);
        end
        MODE_SHL: begin
          q_next   = {q[WIDTH-2:0], ser_in};
          ser_next = q[WIDTH-1];
        end
        MODE_SHR: begin
          q_next   = {ser_in, q[WIDTH-1:1]};
          ser_next = q[0];
        end
        MODE_COUNT: begin
          q_next    = q + WIDTH'(1);
          wrap_next = &q;
        end
        default:    q_next = q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q           <= RESET_VALUE;
      ser_out     <= 1'b0;
      wrap        <= 1'b0;
      sr_conflict <= 1'b0;
    end else begin
      q           <= q_next;
      ser_out     <= ser_next;
      wrap        <= wrap_next;
      sr_conflict <= conflict_next;
    end
  end

endmodule
